// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control stage and the counter chain top level.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_RUNNING = 2'b01;
  localparam state_t ST_PAUSED  = 2'b10;

  localparam int DEFAULT_TICKS_PER_SEC = 100_000_000;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a synchronized, debounced button level.
// The history register resets high so a button held through reset is not a press.
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= btn;
    end
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM and 1 Hz prescaler: turns start/stop/reset presses into
// registered one-cycle enable and clear pulses for the seconds counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int CNT_W         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_stop,
  input  logic               btn_reset,
  output logic               enable,
  output logic               clear,
  output logic               running,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic             start_edge;
  logic             stop_edge;
  logic             reset_edge;
  state_t           state_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_nxt;
  logic             enable_nxt;
  logic             count_cycle;

  btn_edge_detect u_start_edge (.clk(clk), .rst_n(rst_n), .btn(btn_start), .rise(start_edge));
  btn_edge_detect u_stop_edge  (.clk(clk), .rst_n(rst_n), .btn(btn_stop),  .rise(stop_edge));
  btn_edge_detect u_reset_edge (.clk(clk), .rst_n(rst_n), .btn(btn_reset), .rise(reset_edge));

  // A stop or reset press freezes the prescaler in its own cycle, so a pause
  // landing on the last tick never leaks an enable.
  assign count_cycle = (state == ST_RUNNING) && !stop_edge && !reset_edge;

  always_comb begin
    state_nxt = state;
    if (reset_edge) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start_edge && !stop_edge) state_nxt = ST_RUNNING;
        ST_RUNNING: if (stop_edge)                state_nxt = ST_PAUSED;
        ST_PAUSED:  if (start_edge && !stop_edge) state_nxt = ST_RUNNING;
        default:                                  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tick_nxt   = tick_cnt;
    enable_nxt = 1'b0;
    if (reset_edge || (state == ST_IDLE)) begin
      tick_nxt = '0;
    end else if (count_cycle) begin
      if (tick_cnt == TICK_LAST) begin
        tick_nxt   = '0;
        enable_nxt = 1'b1;
      end else begin
        tick_nxt = tick_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      enable   <= 1'b0;
      clear    <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      enable   <= enable_nxt;
      clear    <= reset_edge;
    end
  end

  assign running = (state == ST_RUNNING);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded directed bench for stopwatch_ctrl with TICKS_PER_SEC = 4.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_R = 2'b01;
  localparam logic [1:0] S_P = 2'b10;

  typedef struct {
    logic       en;
    logic       clr;
    logic       run;
    logic [1:0] st;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_reset = 1'b0;
  logic       enable;
  logic       clear;
  logic       running;
  logic [1:0] state;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  event probe_ev;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_reset (btn_reset),
    .enable    (enable),
    .clear     (clear),
    .running   (running),
    .state     (state)
  );

  // Monitor: every clock edge (or async probe) with a pending expectation is checked.
  always begin
    exp_t x;
    @(posedge clk or probe_ev);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if ({enable, clear, running, state} !== {x.en, x.clr, x.run, x.st}) begin
        errors++;
        $display("FAIL step %0d: got en=%0b clr=%0b run=%0b st=%b, want en=%0b clr=%0b run=%0b st=%b",
                 x.id, enable, clear, running, state, x.en, x.clr, x.run, x.st);
      end
    end
  end

  task automatic push_exp(input logic e, input logic c, input logic [1:0] st);
    exp_t x;
    x.en  = e;
    x.clr = c;
    x.run = (st == S_R);
    x.st  = st;
    x.id  = step_id;
    step_id++;
    exp_q.push_back(x);
  endtask

  // Drive inputs for one cycle; expectation is for the outputs after the next posedge.
  task automatic step(input logic rn, input logic s, input logic p, input logic r,
                      input logic e, input logic c, input logic [1:0] st);
    @(negedge clk);
    rst_n     = rn;
    btn_start = s;
    btn_stop  = p;
    btn_reset = r;
    push_exp(e, c, st);
  endtask

  task automatic idle_steps(input int n, input logic rn, input logic s, input logic [1:0] st);
    for (int i = 0; i < n; i++) step(rn, s, 1'b0, 1'b0, 1'b0, 1'b0, st);
  endtask

  // n running cycles with buttons low; enable expected at cycle first, first+4, ...
  task automatic run_steps(input int n, input int first);
    for (int i = 1; i <= n; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, (i >= first) && (((i - first) % 4) == 0), 1'b0, S_R);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    rst_n = 1'b0;
    push_exp(1'b0, 1'b0, S_I);
    -> probe_ev;
  endtask

  initial begin
    // reset and quiet idle
    idle_steps(3, 1'b0, 1'b0, S_I);
    idle_steps(20, 1'b1, 1'b0, S_I);

    // start, run: enable at 4, 8, 12
    step(1, 1, 0, 0, 0, 0, S_R);
    run_steps(14, 4);

    // stop with tick_cnt=2, pause 10, resume: enable 2 cycles later
    step(1, 0, 1, 0, 0, 0, S_P);
    idle_steps(10, 1'b1, 1'b0, S_P);
    step(1, 1, 0, 0, 0, 0, S_R);
    run_steps(4, 2);

    // simultaneous presses
    step(1, 1, 1, 0, 0, 0, S_P);
    step(1, 0, 0, 0, 0, 0, S_P);
    step(1, 1, 1, 1, 0, 1, S_I);
    step(1, 0, 0, 0, 0, 0, S_I);
    step(1, 0, 1, 0, 0, 0, S_I);
    step(1, 0, 0, 0, 0, 0, S_I);

    // reset held while running: one clear, prescaler restarts from 0
    step(1, 1, 0, 0, 0, 0, S_R);
    run_steps(2, 4);
    step(1, 0, 0, 1, 0, 1, S_I);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0, 0, S_I);
    step(1, 0, 0, 0, 0, 0, S_I);
    step(1, 1, 0, 0, 0, 0, S_R);
    run_steps(4, 4);

    // async reset mid-run while enable is high, start held across release
    async_reset_check();
    idle_steps(2, 1'b0, 1'b1, S_I);
    idle_steps(3, 1'b1, 1'b1, S_I);
    idle_steps(1, 1'b1, 1'b0, S_I);
    step(1, 1, 0, 0, 0, 0, S_R);
    step(1, 0, 0, 0, 0, 0, S_R);
    run_steps(3, 3);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: bench did not complete, pending=%0d", exp_q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
